// File: rtl/hex_display_ctrl.sv
// Registered N-digit active-low 7-segment driver: EMPTY (dashes), SHOW (latched hex, timed blink), BUSY (sweep).
// Define HEX_LZB_EN to blank leading zero digits in SHOW; undefined shows every digit.

module hex_seg_lane (
  input  logic [3:0] nib_i,
  input  logic [1:0] sel_i,
  output logic [7:0] hex_o
);
  localparam logic [1:0] SEL_CODE = 2'd0;
  localparam logic [1:0] SEL_DASH = 2'd1;

  logic [6:0] seg;

  always_comb begin
    seg = 7'h7F;
    if (sel_i == SEL_DASH) begin
      seg = 7'h3F;
    end else if (sel_i == SEL_CODE) begin
      case (nib_i)
        4'h0: seg = 7'h40;
        4'h1: seg = 7'h79;
        4'h2: seg = 7'h24;
        4'h3: seg = 7'h30;
        4'h4: seg = 7'h19;
        4'h5: seg = 7'h12;
        4'h6: seg = 7'h02;
        4'h7: seg = 7'h78;
        4'h8: seg = 7'h00;
        4'h9: seg = 7'h10;
        4'hA: seg = 7'h08;
        4'hB: seg = 7'h03;
        4'hC: seg = 7'h46;
        4'hD: seg = 7'h21;
        4'hE: seg = 7'h06;
        default: seg = 7'h0E;
      endcase
    end
    hex_o = {1'b1, seg};
  end
endmodule

module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    clear_i,
  input  logic                    busy_i,
  input  logic                    blink_i,
  output logic [8*NUM_DIGITS-1:0] hex_o,
  output logic                    valid_o
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [1:0] SEL_CODE  = 2'd0;
  localparam logic [1:0] SEL_DASH  = 2'd1;
  localparam logic [1:0] SEL_BLANK = 2'd2;

  typedef enum logic [1:0] {ST_EMPTY, ST_SHOW, ST_BUSY} state_t;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic                    valid_q, valid_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [SW-1:0]           sweep_q, sweep_d;
  logic                    phase_q, phase_d;
  logic [8*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    tick;
  logic [NUM_DIGITS-1:0]   lz;
  logic [NUM_DIGITS-1:0][7:0] lane_hex;

  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    value_d = value_q;
    valid_d = valid_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    sweep_d = sweep_q;
    // Phase only advances while blinking in SHOW; anything else snaps back to visible.
    phase_d = 1'b0;
    if (state_q == ST_SHOW && blink_i) phase_d = phase_q ^ tick;

    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      value_d = value_i;
      valid_d = 1'b1;
      presc_d = '0;
      phase_d = 1'b0;
    end

    state_d = busy_i ? ST_BUSY : (valid_d ? ST_SHOW : ST_EMPTY);

    if (state_d == ST_BUSY) begin
      if (state_q != ST_BUSY)
        sweep_d = '0;
      else if (tick)
        sweep_d = (sweep_q == SW'(NUM_DIGITS - 1)) ? '0 : sweep_q + 1'b1;
    end
  end

`ifdef HEX_LZB_EN
  // Digit k is a leading zero if it and every more-significant nibble are zero; digit 0 never blanks.
  always_comb begin
    logic lead;
    lz   = '0;
    lead = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lead  = lead && (value_q[4*k +: 4] == 4'h0);
      lz[k] = lead;
    end
  end
`else
  assign lz = '0;
`endif

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    logic [1:0] sel;

    always_comb begin
      sel = SEL_DASH;
      case (state_q)
        ST_BUSY: sel = (sweep_q == SW'(k)) ? SEL_DASH : SEL_BLANK;
        ST_SHOW: sel = (phase_q || lz[k]) ? SEL_BLANK : SEL_CODE;
        default: sel = SEL_DASH;
      endcase
    end

    hex_seg_lane u_lane (
      .nib_i (value_q[4*k +: 4]),
      .sel_i (sel),
      .hex_o (lane_hex[k])
    );
  end

  assign hex_d = lane_hex;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_EMPTY;
      value_q <= '0;
      valid_q <= 1'b0;
      presc_q <= '0;
      sweep_q <= '0;
      phase_q <= 1'b0;
      hex_q   <= {NUM_DIGITS{8'hBF}};
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      valid_q <= valid_d;
      presc_q <= presc_d;
      sweep_q <= sweep_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
    end
  end

  assign hex_o   = hex_q;
  assign valid_o = valid_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl at NUM_DIGITS=4, TICK_DIV=4: decode table plus busy/blink/clear/reset sequences.

module tb_hex_display_ctrl;
  logic        Clk;
  logic        Reset;
  logic        load_i;
  logic [15:0] value_i;
  logic        clear_i;
  logic        busy_i;
  logic        blink_i;
  logic [31:0] hex_o;
  logic        valid_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] value;
    logic [31:0] exp_hex;
  } vec_t;

  vec_t vecs [8];

  hex_display_ctrl #(.NUM_DIGITS(4), .TICK_DIV(4)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .load_i  (load_i),
    .value_i (value_i),
    .clear_i (clear_i),
    .busy_i  (busy_i),
    .blink_i (blink_i),
    .hex_o   (hex_o),
    .valid_o (valid_o)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef HEX_LZB_EN
  localparam logic [31:0] V0A3F = 32'hFF88B08E;
`else
  localparam logic [31:0] V0A3F = 32'hC088B08E;
`endif

  initial begin
    vecs[0] = '{16'h0A3F, V0A3F};
    vecs[1] = '{16'h1234, 32'hF9A4B099};
    vecs[2] = '{16'h5678, 32'h9282F880};
    vecs[3] = '{16'h9ABC, 32'h908883C6};
    vecs[4] = '{16'hDEF0, 32'hA1868EC0};
`ifdef HEX_LZB_EN
    vecs[5] = '{16'h0000, 32'hFFFFFFC0};
    vecs[6] = '{16'h00F0, 32'hFFFF8EC0};
`else
    vecs[5] = '{16'h0000, 32'hC0C0C0C0};
    vecs[6] = '{16'h00F0, 32'hC0C08EC0};
`endif
    vecs[7] = '{16'h8000, 32'h80C0C0C0};

    Reset = 1'b1; load_i = 1'b0; value_i = '0; clear_i = 1'b0; busy_i = 1'b0; blink_i = 1'b0;
    @(negedge Clk);
    chk("reset_hex", hex_o, 32'hBFBFBFBF);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    Reset = 1'b0;
    step();
    chk("post_reset_hex", hex_o, 32'hBFBFBFBF);
    chk("post_reset_valid", {31'd0, valid_o}, 32'd0);

    // Decode table: load, one idle cycle, then the value is on hex_o.
    for (int i = 0; i < 8; i++) begin
      load_i = 1'b1; value_i = vecs[i].value;
      step();
      load_i = 1'b0;
      step();
      chk($sformatf("decode_%h", vecs[i].value), hex_o, vecs[i].exp_hex);
      chk($sformatf("valid_%h", vecs[i].value), {31'd0, valid_o}, 32'd1);
    end

    // Busy sweep, load during busy, then busy fall restores the value.
    load_i = 1'b1; value_i = 16'h0A3F;
    step();
    load_i = 1'b0; busy_i = 1'b1;
    step();
    step();  chk("busy_e2", hex_o, 32'hFFFFFFBF);
    steps(2); chk("busy_e4", hex_o, 32'hFFFFFFBF);
    step();  chk("busy_e5", hex_o, 32'hFFFFBFFF);
    steps(4); chk("busy_e9", hex_o, 32'hFFBFFFFF);
    steps(4); chk("busy_e13", hex_o, 32'hBFFFFFFF);
    steps(4); chk("busy_e17_wrap", hex_o, 32'hFFFFFFBF);
    chk("busy_valid", {31'd0, valid_o}, 32'd1);
    load_i = 1'b1; value_i = 16'h1234;
    step();
    load_i = 1'b0;
    step();  chk("busy_load_stays", hex_o, 32'hFFFFFFBF);
    busy_i = 1'b0;
    steps(2); chk("busy_fall_show", hex_o, 32'hF9A4B099);

    // Blink with a reload mid-blink and blink release.
    load_i = 1'b1; value_i = 16'h0A3F; blink_i = 1'b1;
    step();
    load_i = 1'b0;
    step();  chk("blink_e1", hex_o, V0A3F);
    steps(3); chk("blink_e4", hex_o, V0A3F);
    step();  chk("blink_e5_hidden", hex_o, 32'hFFFFFFFF);
    steps(3); chk("blink_e8_hidden", hex_o, 32'hFFFFFFFF);
    step();  chk("blink_e9", hex_o, V0A3F);
    load_i = 1'b1; value_i = 16'h5678;
    step();
    load_i = 1'b0;
    step();  chk("blink_reload", hex_o, 32'h9282F880);
    steps(3); chk("blink_reload_e14", hex_o, 32'h9282F880);
    step();  chk("blink_reload_hidden", hex_o, 32'hFFFFFFFF);
    blink_i = 1'b0;
    steps(2); chk("blink_off", hex_o, 32'h9282F880);

    // clear_i and load_i together: clear wins.
    clear_i = 1'b1; load_i = 1'b1; value_i = 16'hFFFF;
    step();
    clear_i = 1'b0; load_i = 1'b0;
    chk("clr_load_valid", {31'd0, valid_o}, 32'd0);
    step();  chk("clr_load_hex", hex_o, 32'hBFBFBFBF);

    // clear while busy: stays BUSY, then busy fall goes to EMPTY.
    load_i = 1'b1; value_i = 16'h1234;
    step();
    load_i = 1'b0; clear_i = 1'b1; busy_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clr_busy_valid", {31'd0, valid_o}, 32'd0);
    step();  chk("clr_busy_sweep", hex_o, 32'hFFFFFFBF);
    busy_i = 1'b0;
    steps(2); chk("clr_busy_empty", hex_o, 32'hBFBFBFBF);

    // Reset mid-sweep, then sweep restarts from digit 0.
    load_i = 1'b1; value_i = 16'h0A3F;
    step();
    load_i = 1'b0; busy_i = 1'b1;
    steps(6); chk("rst_pre_sweep", hex_o, 32'hFFFFBFFF);
    #2 Reset = 1'b1;
    #1;
    chk("rst_async_hex", hex_o, 32'hBFBFBFBF);
    chk("rst_async_valid", {31'd0, valid_o}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0; busy_i = 1'b0;
    steps(2); chk("rst_after_hex", hex_o, 32'hBFBFBFBF);
    busy_i = 1'b1;
    steps(2); chk("rst_sweep_restart", hex_o, 32'hFFFFFFBF);
    busy_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
